// File: rtl/lfsr_gen.sv
// Parameterised Fibonacci/Galois LFSR with multi-step advance, all-zero escape,
// step counting and period detection against the latched seed.
module lfsr_gen #(
    parameter int WIDTH      = 16,
    parameter int MODE       = 0,
    parameter int STEP       = 1,
    parameter int LOCKUP_FIX = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reinit,
    input  logic             advance,
    input  logic [WIDTH-1:0] initial_state,
    input  logic [WIDTH-1:0] taps,
    output logic             out,
    output logic [WIDTH-1:0] out_state,
    output logic [STEP-1:0]  out_word,
    output logic             out_valid,
    output logic             lockup,
    output logic [CNT_W-1:0] step_count,
    output logic             period_hit,
    output logic [CNT_W-1:0] period
);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be in 2..64");
        end
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("lfsr_gen: MODE must be 0 or 1");
        end
        if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
            $error("lfsr_gen: STEP must be in 1..WIDTH");
        end
        if (LOCKUP_FIX != 0 && LOCKUP_FIX != 1) begin : g_bad_fix
            $error("lfsr_gen: LOCKUP_FIX must be 0 or 1");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("lfsr_gen: CNT_W must be at least 1");
        end
    endgenerate

    // One LFSR sub-step; Galois never feeds taps[0] because bit 0 takes the MSB directly.
    function automatic logic [WIDTH-1:0] sub_step(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] t);
        logic             fb;
        logic [WIDTH-1:0] gmask;
        logic [WIDTH-1:0] res;
        fb    = 1'b0;
        gmask = t & {WIDTH{s[WIDTH-1]}};
        gmask[0] = 1'b0;
        if (MODE == 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                fb = fb ^ (t[i] & s[i]);
            end
            res = {s[WIDTH-2:0], fb};
        end else begin
            res = {s[WIDTH-2:0], s[WIDTH-1]} ^ gmask;
        end
        return res;
    endfunction

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] seed_r;
    logic [STEP-1:0]  word_r;
    logic             valid_r;
    logic             hit_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] period_r;

    logic [WIDTH-1:0] walk_s;
    logic [STEP-1:0]  walk_word_s;
    logic [WIDTH-1:0] next_state_s;
    logic [STEP-1:0]  next_word_s;
    logic             zero_s;

    assign zero_s = (state_r == {WIDTH{1'b0}});

    // Unrolled STEP sub-steps, with the all-zero escape overriding the walk.
    always_comb begin
        walk_s      = state_r;
        walk_word_s = {STEP{1'b0}};
        for (int k = 0; k < STEP; k++) begin
            walk_s         = sub_step(walk_s, taps);
            walk_word_s[k] = walk_s[0];
        end
        if (LOCKUP_FIX == 1 && zero_s) begin
            next_state_s = {{(WIDTH-1){1'b0}}, 1'b1};
            next_word_s  = {STEP{1'b0}};
        end else begin
            next_state_s = walk_s;
            next_word_s  = walk_word_s;
        end
    end

    // State, seed, tracking and pulse registers; rst beats reinit beats advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= initial_state;
            seed_r   <= initial_state;
            cnt_r    <= {CNT_W{1'b0}};
            period_r <= {CNT_W{1'b0}};
            word_r   <= {STEP{1'b0}};
            valid_r  <= 1'b0;
            hit_r    <= 1'b0;
        end else if (reinit) begin
            state_r <= initial_state;
            seed_r  <= initial_state;
            cnt_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            hit_r   <= 1'b0;
        end else if (advance) begin
            state_r <= next_state_s;
            word_r  <= next_word_s;
            valid_r <= 1'b1;
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (next_state_s == seed_r) begin
                hit_r    <= 1'b1;
                period_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                hit_r    <= 1'b0;
            end
        end else begin
            valid_r <= 1'b0;
            hit_r   <= 1'b0;
        end
    end

    assign out        = state_r[0];
    assign out_state  = state_r;
    assign out_word   = word_r;
    assign out_valid  = valid_r;
    assign lockup     = zero_s;
    assign step_count = cnt_r;
    assign period_hit = hit_r;
    assign period     = period_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: four small 4-bit instances share clock and controls
// (Fibonacci STEP=1, Fibonacci STEP=2, Galois, Fibonacci without lockup escape).
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, reinit, advance;
    logic [3:0] a_seed, b_seed, c_seed, d_seed;
    logic [3:0] a_taps, b_taps, c_taps, d_taps;

    logic        a_out, b_out, c_out, d_out;
    logic [3:0]  a_state, b_state, c_state, d_state;
    logic [0:0]  a_word, c_word, d_word;
    logic [1:0]  b_word;
    logic        a_valid, b_valid, c_valid, d_valid;
    logic        a_lock, b_lock, c_lock, d_lock;
    logic [31:0] a_cnt, b_cnt, c_cnt, d_cnt;
    logic        a_hit, b_hit, c_hit, d_hit;
    logic [31:0] a_per, b_per, c_per, d_per;

    lfsr_gen #(.WIDTH(4), .MODE(0), .STEP(1), .LOCKUP_FIX(1), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
        .initial_state(a_seed), .taps(a_taps), .out(a_out), .out_state(a_state),
        .out_word(a_word), .out_valid(a_valid), .lockup(a_lock), .step_count(a_cnt),
        .period_hit(a_hit), .period(a_per));

    lfsr_gen #(.WIDTH(4), .MODE(0), .STEP(2), .LOCKUP_FIX(1), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
        .initial_state(b_seed), .taps(b_taps), .out(b_out), .out_state(b_state),
        .out_word(b_word), .out_valid(b_valid), .lockup(b_lock), .step_count(b_cnt),
        .period_hit(b_hit), .period(b_per));

    lfsr_gen #(.WIDTH(4), .MODE(1), .STEP(1), .LOCKUP_FIX(1), .CNT_W(32)) u_c (
        .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
        .initial_state(c_seed), .taps(c_taps), .out(c_out), .out_state(c_state),
        .out_word(c_word), .out_valid(c_valid), .lockup(c_lock), .step_count(c_cnt),
        .period_hit(c_hit), .period(c_per));

    lfsr_gen #(.WIDTH(4), .MODE(0), .STEP(1), .LOCKUP_FIX(0), .CNT_W(32)) u_d (
        .clk(clk), .rst(rst), .reinit(reinit), .advance(advance),
        .initial_state(d_seed), .taps(d_taps), .out(d_out), .out_state(d_state),
        .out_word(d_word), .out_valid(d_valid), .lockup(d_lock), .step_count(d_cnt),
        .period_hit(d_hit), .period(d_per));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] state;
        logic       hit;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // Hand-computed x^4+x^3+1 walk from 0001 with taps 1100.
        vecs[0]  = '{4'b0010, 1'b0};
        vecs[1]  = '{4'b0100, 1'b0};
        vecs[2]  = '{4'b1001, 1'b0};
        vecs[3]  = '{4'b0011, 1'b0};
        vecs[4]  = '{4'b0110, 1'b0};
        vecs[5]  = '{4'b1101, 1'b0};
        vecs[6]  = '{4'b1010, 1'b0};
        vecs[7]  = '{4'b0101, 1'b0};
        vecs[8]  = '{4'b1011, 1'b0};
        vecs[9]  = '{4'b0111, 1'b0};
        vecs[10] = '{4'b1111, 1'b0};
        vecs[11] = '{4'b1110, 1'b0};
        vecs[12] = '{4'b1100, 1'b0};
        vecs[13] = '{4'b1000, 1'b0};
        vecs[14] = '{4'b0001, 1'b1};

        rst = 1'b1; reinit = 1'b0; advance = 1'b0;
        a_seed = 4'b0001; a_taps = 4'b1100;
        b_seed = 4'b0001; b_taps = 4'b1100;
        c_seed = 4'b1000; c_taps = 4'b0011;
        d_seed = 4'b0000; d_taps = 4'b1100;
        tick();
        rst = 1'b0;
        chk("rst_state", 64'(a_state), 64'h1);
        chk("rst_cnt", 64'(a_cnt), 64'h0);
        chk("rst_period", 64'(a_per), 64'h0);
        chk("rst_valid", 64'(a_valid), 64'h0);
        chk("rst_hit", 64'(a_hit), 64'h0);
        chk("rst_word", 64'(a_word), 64'h0);
        chk("rst_out", 64'(a_out), 64'h1);
        chk("rst_d_lockup", 64'(d_lock), 64'h1);

        advance = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("per_state", 64'(a_state), 64'(vecs[i].state));
            chk("per_hit", 64'(a_hit), 64'(vecs[i].hit));
            chk("per_cnt", 64'(a_cnt), 64'(i + 1));
            chk("per_valid", 64'(a_valid), 64'h1);
            chk("per_word", 64'(a_word), 64'(vecs[i].state[0]));
            chk("d_stuck", 64'({d_lock, d_state}), 64'h10);
            if (i == 0) begin
                chk("ms_state1", 64'(b_state), 64'h4);
                chk("ms_word1", 64'(b_word), 64'h0);
                chk("gal_state", 64'(c_state), 64'h3);
                chk("gal_valid1", 64'(c_valid), 64'h1);
            end else if (i == 1) begin
                chk("ms_state2", 64'(b_state), 64'h3);
                chk("ms_word2", 64'(b_word), 64'h3);
                chk("gal_valid2", 64'(c_valid), 64'h1);
            end else begin
                chk("ms_cnt", 64'(b_cnt), 64'(i + 1));
            end
        end
        chk("period15", 64'(a_per), 64'd15);

        advance = 1'b0;
        tick();
        chk("idle_valid", 64'(a_valid), 64'h0);
        chk("idle_hit", 64'(a_hit), 64'h0);
        chk("idle_state", 64'(a_state), 64'h1);
        chk("idle_word", 64'(a_word), 64'h1);
        chk("idle_cnt", 64'(a_cnt), 64'd15);

        advance = 1'b1;
        repeat (3) tick();
        chk("mid_state", 64'(a_state), 64'h9);
        chk("mid_cnt", 64'(a_cnt), 64'd18);

        advance = 1'b0; reinit = 1'b1; a_seed = 4'b0110;
        tick();
        chk("reinit_state", 64'(a_state), 64'h6);
        chk("reinit_cnt", 64'(a_cnt), 64'h0);
        chk("reinit_period", 64'(a_per), 64'd15);
        chk("reinit_valid", 64'(a_valid), 64'h0);

        advance = 1'b1; a_seed = 4'b1010;
        tick();
        chk("reinit_adv_state", 64'(a_state), 64'hA);
        chk("reinit_adv_cnt", 64'(a_cnt), 64'h0);
        chk("reinit_adv_valid", 64'(a_valid), 64'h0);

        rst = 1'b1; a_seed = 4'b0101;
        tick();
        rst = 1'b0;
        chk("all3_state", 64'(a_state), 64'h5);
        chk("all3_cnt", 64'(a_cnt), 64'h0);
        chk("all3_valid", 64'(a_valid), 64'h0);
        chk("all3_period", 64'(a_per), 64'h0);

        // Tap change applies on the next advance without reloading state.
        reinit = 1'b0; advance = 1'b0; a_taps = 4'b1001;
        tick();
        chk("tap_hold", 64'(a_state), 64'h5);
        advance = 1'b1;
        tick();
        chk("tap_live", 64'(a_state), 64'hB);

        advance = 1'b0; reinit = 1'b1; a_seed = 4'b0000; a_taps = 4'b1100;
        tick();
        reinit = 1'b0;
        chk("lock_state", 64'(a_state), 64'h0);
        chk("lock_flag", 64'(a_lock), 64'h1);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("unlock_state", 64'(a_state), 64'h1);
        chk("unlock_flag", 64'(a_lock), 64'h0);
        chk("unlock_cnt", 64'(a_cnt), 64'h1);
        chk("unlock_word", 64'(a_word), 64'h0);
        chk("unlock_valid", 64'(a_valid), 64'h1);
        chk("d_final", 64'({d_lock, d_state}), 64'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
